regfile_wb_scoreboard: RTL and testbench

- Register file at the receiving end of the write-back path: consumes `RegWrite` / `in_WriteReg` / `in_WriteData` from the write-back stage and serves the two decode-stage read ports.
- Keeps a per-register pending-write scoreboard. Decode marks a destination busy at issue; the matching write-back clears it.
- Raises `out_Stall` when an issuing instruction depends on a register whose write-back has not yet arrived.
- Sits between the decode stage and the write-back stage of the 16-bit MIPS pipeline.

---
 rtl/regfile_wb_scoreboard.sv | 94 +++++++++
 tb/tb_regfile_wb_scoreboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scoreboard.sv
// Write-back register file with per-register pending-write scoreboard.
// Serves two bypassed decode read ports and flags RAW/WAW hazards at issue.
module regfile_wb_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                RegWrite,
    input  logic [ADDR_W-1:0]   in_WriteReg,
    input  logic [DATA_W-1:0]   in_WriteData,
    input  logic [ADDR_W-1:0]   in_ReadReg1,
    input  logic [ADDR_W-1:0]   in_ReadReg2,
    output logic [DATA_W-1:0]   out_ReadData1,
    output logic [DATA_W-1:0]   out_ReadData2,
    input  logic                issue_valid,
    input  logic                issue_writes,
    input  logic [ADDR_W-1:0]   issue_dest,
    output logic                out_Stall,
    output logic [NUM_REGS-1:0] out_Busy,
    output logic [ADDR_W:0]     out_Pending
);

    logic [DATA_W-1:0]   regFile [NUM_REGS];
    logic [NUM_REGS-1:0] busyReg;
    logic [NUM_REGS-1:0] busyNext;
    logic [NUM_REGS-1:0] effBusy;
    logic [ADDR_W:0]     pendingReg;
    logic [ADDR_W:0]     pendingNext;
    logic                issueAccept;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= '0;
            end
        end else if (RegWrite && (in_WriteReg != '0)) begin
            regFile[in_WriteReg] <= in_WriteData;
        end
    end

    // A write-back landing this cycle is forwarded straight to the readers.
    assign out_ReadData1 = (in_ReadReg1 == '0) ? '0 :
                           (RegWrite && (in_WriteReg == in_ReadReg1)) ? in_WriteData :
                           regFile[in_ReadReg1];
    assign out_ReadData2 = (in_ReadReg2 == '0) ? '0 :
                           (RegWrite && (in_WriteReg == in_ReadReg2)) ? in_WriteData :
                           regFile[in_ReadReg2];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : gScoreboard
            if (gi == 0) begin : gZero
                assign effBusy[gi]  = 1'b0;
                assign busyNext[gi] = 1'b0;
            end else begin : gEntry
                logic setBit;
                logic clrBit;
                assign clrBit = RegWrite && (in_WriteReg == ADDR_W'(gi));
                assign setBit = issueAccept && issue_writes && (issue_dest == ADDR_W'(gi));
                assign effBusy[gi] = busyReg[gi] && !clrBit;
                // A same-cycle write-back belongs to the older instruction, so the new mark wins.
                assign busyNext[gi] = setBit ? 1'b1 : (clrBit ? 1'b0 : busyReg[gi]);
            end
        end
    endgenerate

    assign out_Stall = issue_valid && (effBusy[in_ReadReg1] || effBusy[in_ReadReg2] ||
                                       (issue_writes && effBusy[issue_dest]));
    assign issueAccept = issue_valid && !out_Stall;

    always_comb begin
        pendingNext = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pendingNext = pendingNext + (ADDR_W+1)'(busyNext[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyReg    <= '0;
            pendingReg <= '0;
        end else begin
            busyReg    <= busyNext;
            pendingReg <= pendingNext;
        end
    end

    assign out_Busy    = busyReg;
    assign out_Pending = pendingReg;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Bench for regfile_wb_scoreboard: directed scenarios plus randomized traffic
// checked against an in-order architectural model of registers and outstanding writes.
module tb_regfile_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [2:0]  in_WriteReg;
    logic [15:0] in_WriteData;
    logic [2:0]  in_ReadReg1;
    logic [2:0]  in_ReadReg2;
    logic [15:0] out_ReadData1;
    logic [15:0] out_ReadData2;
    logic        issue_valid;
    logic        issue_writes;
    logic [2:0]  issue_dest;
    logic        out_Stall;
    logic [7:0]  out_Busy;
    logic [3:0]  out_Pending;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register values and the set of outstanding writes.
    logic [15:0] mRegs [8];
    bit          mOutstanding [8];

    regfile_wb_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .RegWrite(RegWrite), .in_WriteReg(in_WriteReg), .in_WriteData(in_WriteData),
        .in_ReadReg1(in_ReadReg1), .in_ReadReg2(in_ReadReg2),
        .out_ReadData1(out_ReadData1), .out_ReadData2(out_ReadData2),
        .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dest(issue_dest),
        .out_Stall(out_Stall), .out_Busy(out_Busy), .out_Pending(out_Pending)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        for (int i = 0; i < 8; i++) begin
            mRegs[i] = 16'h0000;
            mOutstanding[i] = 1'b0;
        end
    endfunction

    // A register the instruction must wait for: outstanding and not arriving right now.
    function automatic bit waitFor(input logic [2:0] r);
        return (r != 0) && mOutstanding[r] && !(RegWrite && in_WriteReg == r);
    endfunction

    function automatic logic [15:0] expRead(input logic [2:0] r);
        if (r == 0) return 16'h0000;
        if (RegWrite && in_WriteReg == r) return in_WriteData;
        return mRegs[r];
    endfunction

    function automatic bit expStall();
        return issue_valid && (waitFor(in_ReadReg1) || waitFor(in_ReadReg2) ||
                               (issue_writes && waitFor(issue_dest)));
    endfunction

    function automatic logic [7:0] expBusy();
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v[i] = mOutstanding[i];
        return v;
    endfunction

    function automatic logic [3:0] expPending();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(mOutstanding[i]);
        return 4'(n);
    endfunction

    task automatic setIn(input logic rw, input logic [2:0] wr, input logic [15:0] wd,
                         input logic [2:0] r1, input logic [2:0] r2,
                         input logic iv, input logic iw, input logic [2:0] id);
        RegWrite = rw; in_WriteReg = wr; in_WriteData = wd;
        in_ReadReg1 = r1; in_ReadReg2 = r2;
        issue_valid = iv; issue_writes = iw; issue_dest = id;
    endtask

    // Advance one clock and retire the cycle in the model: older write-back first, then the issue.
    task automatic tick();
        bit accept;
        accept = issue_valid && !expStall();
        @(posedge clk);
        if (RegWrite) begin
            if (in_WriteReg != 0) mRegs[in_WriteReg] = in_WriteData;
            mOutstanding[in_WriteReg] = 1'b0;
        end
        if (accept && issue_writes && issue_dest != 0) mOutstanding[issue_dest] = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        setIn(1'b0, 3'd0, 16'h0, 3'd1, 3'd7, 1'b1, 1'b1, 3'd1);
        modelReset();
        #12;
        checks++; if (out_ReadData1 !== 16'h0000) begin errors++; $display("FAIL reset_rd1: got %h expected 0000", out_ReadData1); end
        checks++; if (out_ReadData2 !== 16'h0000) begin errors++; $display("FAIL reset_rd2: got %h expected 0000", out_ReadData2); end
        checks++; if (out_Busy !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h expected 00", out_Busy); end
        checks++; if (out_Pending !== 4'd0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", out_Pending); end
        checks++; if (out_Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", out_Stall); end
        issue_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_bypass();
        setIn(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 1'b0, 1'b0, 3'd0);
        #1;
        checks++; if (out_ReadData1 !== 16'hBEEF) begin errors++; $display("FAIL bypass_rd1: got %h expected beef", out_ReadData1); end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++; if (out_ReadData1 !== 16'hBEEF) begin errors++; $display("FAIL stored_rd1: got %h expected beef", out_ReadData1); end
    endtask

    task automatic test_reg0();
        setIn(1'b1, 3'd0, 16'h1234, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        #1;
        checks++; if (out_ReadData1 !== 16'h0000) begin errors++; $display("FAIL reg0_bypass: got %h expected 0000", out_ReadData1); end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++; if (out_ReadData1 !== 16'h0000) begin errors++; $display("FAIL reg0_stored: got %h expected 0000", out_ReadData1); end
        checks++; if (out_Busy[0] !== 1'b0) begin errors++; $display("FAIL reg0_busy: got %b expected 0", out_Busy[0]); end
    endtask

    task automatic test_issue_stall();
        setIn(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b1, 3'd5);
        #1;
        checks++; if (out_Stall !== 1'b0) begin errors++; $display("FAIL issue5_stall: got %b expected 0", out_Stall); end
        tick();
        setIn(1'b0, 3'd0, 16'h0, 3'd0, 3'd5, 1'b1, 1'b0, 3'd0);
        #1;
        checks++; if (out_Busy !== 8'h20) begin errors++; $display("FAIL issue5_busy: got %h expected 20", out_Busy); end
        checks++; if (out_Pending !== 4'd1) begin errors++; $display("FAIL issue5_pending: got %0d expected 1", out_Pending); end
        checks++; if (out_Stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b expected 1", out_Stall); end
        RegWrite = 1'b1; in_WriteReg = 3'd5; in_WriteData = 16'h00AA;
        #1;
        checks++; if (out_Stall !== 1'b0) begin errors++; $display("FAIL wb_unstall: got %b expected 0", out_Stall); end
        checks++; if (out_ReadData2 !== 16'h00AA) begin errors++; $display("FAIL wb_rd2: got %h expected 00aa", out_ReadData2); end
        tick();
        setIn(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        #1;
        checks++; if (out_Busy !== 8'h00) begin errors++; $display("FAIL wb_busy: got %h expected 00", out_Busy); end
        checks++; if (out_Pending !== 4'd0) begin errors++; $display("FAIL wb_pending: got %0d expected 0", out_Pending); end
    endtask

    task automatic test_same_cycle();
        setIn(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b1, 3'd5);
        tick();
        setIn(1'b1, 3'd5, 16'h5555, 3'd0, 3'd0, 1'b1, 1'b1, 3'd5);
        #1;
        checks++; if (out_Stall !== 1'b0) begin errors++; $display("FAIL waw_resolved_stall: got %b expected 0", out_Stall); end
        tick();
        setIn(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        #1;
        checks++; if (out_Busy !== 8'h20) begin errors++; $display("FAIL setwins_busy: got %h expected 20", out_Busy); end
        checks++; if (out_Pending !== 4'd1) begin errors++; $display("FAIL setwins_pending: got %0d expected 1", out_Pending); end
        setIn(1'b1, 3'd5, 16'h0505, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        tick();
        RegWrite = 1'b0;
        #1;
        checks++; if (out_Pending !== 4'd0) begin errors++; $display("FAIL setwins_drain: got %0d expected 0", out_Pending); end
    endtask

    task automatic test_async_reset();
        setIn(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b1, 3'd2);
        tick();
        issue_dest = 3'd4;
        tick();
        issue_dest = 3'd6;
        tick();
        issue_valid = 1'b0;
        #1;
        checks++; if (out_Busy !== 8'h54) begin errors++; $display("FAIL three_busy: got %h expected 54", out_Busy); end
        checks++; if (out_Pending !== 4'd3) begin errors++; $display("FAIL three_pending: got %0d expected 3", out_Pending); end
        in_ReadReg1 = 3'd3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checks++; if (out_Busy !== 8'h00) begin errors++; $display("FAIL async_busy: got %h expected 00", out_Busy); end
        checks++; if (out_Pending !== 4'd0) begin errors++; $display("FAIL async_pending: got %0d expected 0", out_Pending); end
        checks++; if (out_ReadData1 !== 16'h0000) begin errors++; $display("FAIL async_rd1: got %h expected 0000", out_ReadData1); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [7:0] eb;
        for (int n = 0; n < 500; n++) begin
            setIn(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                  3'($urandom), 3'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 3'($urandom));
            #1;
            checks++; if (out_ReadData1 !== expRead(in_ReadReg1)) begin errors++; $display("FAIL rand_rd1 n=%0d: got %h expected %h", n, out_ReadData1, expRead(in_ReadReg1)); end
            checks++; if (out_ReadData2 !== expRead(in_ReadReg2)) begin errors++; $display("FAIL rand_rd2 n=%0d: got %h expected %h", n, out_ReadData2, expRead(in_ReadReg2)); end
            checks++; if (out_Stall !== expStall()) begin errors++; $display("FAIL rand_stall n=%0d: got %b expected %b", n, out_Stall, expStall()); end
            tick();
            eb = expBusy();
            checks++; if (out_Busy !== eb) begin errors++; $display("FAIL rand_busy n=%0d: got %h expected %h", n, out_Busy, eb); end
            checks++; if (out_Pending !== expPending()) begin errors++; $display("FAIL rand_pending n=%0d: got %0d expected %0d", n, out_Pending, expPending()); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_reg0();
        test_issue_stall();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
